// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: latch write-enables/flushes and PC enable.
// Optional PIPE_PERF_EN adds stall and branch-flush performance counters.
module pipeline_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dMemREN,
    input  logic             exmem_dMemWEN,
    input  logic             idex_dMemREN,
    input  logic [4:0]       idex_writeReg,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              timeout_set;
    logic              dreq, freeze, loaduse;

    assign dreq    = exmem_dMemREN | exmem_dMemWEN;
    assign freeze  = dreq & ~dhit;
    assign loaduse = idex_dMemREN && (idex_writeReg != 5'd0) &&
                     ((idex_writeReg == ifid_rs) || (ifid_uses_rt && (idex_writeReg == ifid_rt)));

    // MEMWAIT shares the RUN priority chain: the freeze branch keeps it waiting,
    // and the dhit cycle resolves any held branch or load-use exactly as RUN would.
    always_comb begin
        pc_en       = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_next  = state;
        wait_next   = wait_cnt;
        timeout_set = 1'b0;

        case (state)
            RUN, MEMWAIT: begin
                state_next = RUN;
                wait_next  = '0;
                if (memwb_halt) begin
                    {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen} = '0;
                    state_next = HALT;
                end else if (freeze) begin
                    {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen} = '0;
                    state_next = MEMWAIT;
                    if (state == RUN)
                        wait_next = WAIT_W'(1);
                    else if (wait_cnt != WAIT_MAX)
                        wait_next = wait_cnt + 1'b1;
                    else
                        wait_next = wait_cnt;
                    timeout_set = (wait_next == WAIT_MAX);
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (loaduse) begin
                    pc_en      = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            HALT: begin
                {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen} = '0;
            end
            default: state_next = RUN;
        endcase

        if (RST) begin
            {pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen} = '0;
            {ifid_flush, idex_flush, exmem_flush} = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == HALT)
                halted <= 1'b1;
            if (timeout_set)
                mem_timeout <= 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             branch_fire;

    assign branch_fire = (state != HALT) && !memwb_halt && !freeze && branch_taken;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state != HALT))
                stall_q <= stall_q + 1'b1;
            if (branch_fire)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC enable. Inputs are cache hit status, load-use register comparisons, branch/jump resolution and halt. It sits beside the datapath, and every pipeline latch `writeEN`/`flush` pair is sourced from it.

Parameters:
MAX_WAIT, 64, number of consecutive MEMWAIT cycles after which `mem_timeout` is raised.
CNT_W, 32, width of the performance counters (used only with PIPE_PERF_EN).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
ihit  input  1  instruction cache hit this cycle
dhit  input  1  data cache hit this cycle
exmem_dMemREN  input  1  load in MEM stage
exmem_dMemWEN  input  1  store in MEM stage
idex_dMemREN  input  1  load in EX stage
idex_writeReg  input  5  destination register of the EX-stage instruction
ifid_rs  input  5  rs of the decode-stage instruction
ifid_rt  input  5  rt of the decode-stage instruction
ifid_uses_rt  input  1  decode-stage instruction reads rt
branch_taken  input  1  taken branch or jump resolved in EX/MEM; younger stages are wrong-path
memwb_halt  input  1  halt instruction has reached MEM/WB
pc_en  output  1  PC register update enable
ifid_wen, idex_wen, exmem_wen, memwb_wen  output  1 each  latch write enables
ifid_flush, idex_flush, exmem_flush  output  1 each  latch flush (load bubble)
halted  output  1  sticky; processor stopped
mem_timeout  output  1  sticky; MEMWAIT exceeded MAX_WAIT
stall_cycles  output  CNT_W  total frozen/stalled cycles (PIPE_PERF_EN)
flush_count  output  CNT_W  number of branch flushes (PIPE_PERF_EN)

Behaviour:
- FSM states: RUN, MEMWAIT, HALT. Outputs are combinational from state and inputs. State and counters are registered.
- Reset (RST=1 at a rising edge):
  - state becomes RUN; wait counter, `halted`, `mem_timeout` and perf counters become 0.
  - While RST is high, outputs are forced: all `*_wen`=0, `pc_en`=0, all `*_flush`=1.
- Definitions:
  - `dreq` = `exmem_dMemREN` | `exmem_dMemWEN`.
  - `freeze` = `dreq` & !`dhit`.
  - `loaduse` = `idex_dMemREN` & (`idex_writeReg`!=0) & ((`idex_writeReg`==`ifid_rs`) | (`ifid_uses_rt` & `idex_writeReg`==`ifid_rt`)).
- Default in RUN: all `wen`=1, `pc_en`=1, all `flush`=0.
- Priority in RUN (highest first):
  1. `memwb_halt`: all `wen`=0, `pc_en`=0. Next state HALT, `halted`<=1.
  2. `freeze`: all `wen`=0, `pc_en`=0, no flushes. Next state MEMWAIT, wait counter<=1.
  3. `branch_taken`: `ifid_flush`=1, `idex_flush`=1, `exmem_flush`=1 (wrong-path ops squashed). `pc_en`=1 to load the target. `branch_taken` takes precedence over `loaduse` and ihit miss.
  4. `loaduse`: `pc_en`=0, `ifid_wen`=0, `idex_flush`=1, `exmem_wen`=1, `memwb_wen`=1. Exactly one bubble, because the load leaves EX next cycle.
  5. !`ihit`: `pc_en`=0, `ifid_flush`=1. Downstream stages advance.
- MEMWAIT:
  - While `freeze`: outputs as in RUN rule 2, and the wait counter increments, saturating at MAX_WAIT.
  - When the counter reaches MAX_WAIT, `mem_timeout`<=1 (sticky). The machine stays in MEMWAIT.
  - When `dhit`=1: outputs are evaluated exactly as RUN on that same cycle, including any pending `branch_taken` or `loaduse`. Next state RUN, counter<=0.
- HALT: all `wen`=0, `pc_en`=0, flushes=0. Remains until RST.
- Simultaneous events:
  - `freeze` with `branch_taken`: freeze wins. The branch is held in EX/MEM and its flush is applied on the `dhit` cycle.
  - `memwb_halt` with `freeze`: halt wins.
- Reset mid-MEMWAIT: returns to RUN next cycle and the counter clears.

Optional Feature:
PIPE_PERF_EN
- Defined:
  - `stall_cycles` increments on every cycle where `pc_en`=0 and state!=HALT.
  - `flush_count` increments on every cycle where RUN rule 3 fires.
  - Both wrap at 2^CNT_W and clear on RST.
- Undefined: both outputs are tied to 0 and no counter registers exist.

Test Plan:
- RST=1 for 2 cycles, then release with ihit=1 and no hazards -> during reset all wen=0 and flushes=1; the first cycle after release has all wen=1, pc_en=1, flushes=0.
- idex_dMemREN=1, idex_writeReg=5, ifid_rs=5, ihit=1 for 1 cycle -> pc_en=0, ifid_wen=0, idex_flush=1 for exactly 1 cycle. Repeat with idex_writeReg=0 -> no stall.
- exmem_dMemREN=1, dhit=0 for 3 cycles then dhit=1 -> all wen=0 for 3 cycles; cycle 4 has all wen=1; stall_cycles=3 with PIPE_PERF_EN.
- branch_taken=1 together with loaduse true and ihit=0 -> ifid_flush=idex_flush=exmem_flush=1, pc_en=1; flush_count=1 with PIPE_PERF_EN.
- MAX_WAIT=4, exmem_dMemWEN=1 with dhit=0 for 6 cycles -> mem_timeout=1 from the cycle after the 4th wait cycle and stays 1 after dhit. RST clears it.
- memwb_halt=1 with dhit=0 and exmem_dMemREN=1 -> next state HALT, halted=1, all wen=0 held for 10 cycles regardless of inputs; RST returns to RUN.
